// File: rtl/cordic_arb.sv
// -----------------------------------------------------------------------------
// cordic_arb
//
// Shares one pipelined CORDIC core (vectoring / ANGLE mode) between NREQ
// requesters. A round-robin arbiter accepts at most one x/y pair per cycle and
// registers it onto the core input. The id of the accepted requester is pushed
// into a tag FIFO. Because the core is an in-order pipeline, the tag at the
// head of the FIFO always belongs to the next core output. Each core output
// pops one tag and is re-broadcast as a one-cycle result strobe carrying the
// owner id.
//
// Ports
//   clk, rst_n            clock (rising edge) and asynchronous active-low reset
//   req_valid/req_ready   per-requester handshake (one bit per requester)
//   req_x, req_y          packed operands, requester i at [i*IDW +: IDW]
//   co_dv/co_x/co_y/co_z  issue port towards the core (co_z tied to 0)
//   ci_dv/ci_angle/ci_amp return port from the core
//   res_valid/res_id/     one-cycle result strobe with owner id; no
//   res_angle/res_amp     back-pressure, so the consumer must take every strobe
//   outstanding           number of tags in flight (0..TDEPTH)
//   err_orphan            sticky: the core produced an output with no tag
// -----------------------------------------------------------------------------
module cordic_arb #(
  parameter int NREQ    = 4,             // requesters, 2..8
  parameter int IDW     = 16,            // operand width
  parameter int ODW     = IDW + 2,       // core amplitude width
  parameter int AW      = 20,            // core angle width, 2^AW == 2*pi
  parameter int TDEPTH  = 32,            // tag FIFO depth, power of two
  parameter int IDW_TAG = $clog2(NREQ)   // requester id width
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*IDW-1:0]     req_x,
  input  logic [NREQ*IDW-1:0]     req_y,
  output logic                    co_dv,
  output logic [IDW-1:0]          co_x,
  output logic [IDW-1:0]          co_y,
  output logic [AW-1:0]           co_z,
  input  logic                    ci_dv,
  input  logic [AW-1:0]           ci_angle,
  input  logic [ODW-1:0]          ci_amp,
  output logic                    res_valid,
  output logic [IDW_TAG-1:0]      res_id,
  output logic [AW-1:0]           res_angle,
  output logic [ODW-1:0]          res_amp,
  output logic [$clog2(TDEPTH):0] outstanding,
  output logic                    err_orphan
);

  localparam int PW = $clog2(TDEPTH);  // FIFO pointer width
  localparam int CW = PW + 1;          // occupancy width, can hold TDEPTH

  // ---------------------------------------------------------------------------
  // Arbitration state and tag FIFO storage
  // ---------------------------------------------------------------------------
  logic [IDW_TAG-1:0] rr_ptr;          // first requester searched this cycle
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic [IDW_TAG-1:0] tag_mem [TDEPTH];

  logic               grant_found;
  logic [IDW_TAG-1:0] grant_id;
  logic [IDW-1:0]     grant_x;
  logic [IDW-1:0]     grant_y;
  logic               fifo_full;
  logic               fifo_empty;
  logic               issue;
  logic               pop;

  // Occupancy is taken from the counter as it stands at the start of the
  // cycle, so a pop in the same cycle never frees room for an issue, and a
  // push in the same cycle never makes a core output look owned.
  assign fifo_full  = (outstanding == CW'(TDEPTH));
  assign fifo_empty = (outstanding == '0);

  // Round-robin search: walk NREQ positions starting at rr_ptr, wrapping past
  // NREQ-1, and keep the first requester that is valid.
  always_comb begin
    // NOTE: every variable written here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    grant_found = 1'b0;
    grant_id    = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!grant_found && req_valid[(int'(rr_ptr) + k) % NREQ]) begin
        grant_found = 1'b1;
        grant_id    = IDW_TAG'((int'(rr_ptr) + k) % NREQ);
      end
    end
  end

  assign grant_x = req_x[int'(grant_id) * IDW +: IDW];
  assign grant_y = req_y[int'(grant_id) * IDW +: IDW];

  // rst_n gates the accept so that no requester sees ready while the block
  // is held in reset, even though rr_ptr and the counter are already zero.
  assign issue = rst_n && grant_found && !fifo_full;
  assign pop   = ci_dv && !fifo_empty;

  // Only the granted requester may see ready; at most one bit is set.
  always_comb begin
    req_ready = '0;
    if (issue) begin
      req_ready[grant_id] = 1'b1;
    end
  end

  // The core runs in ANGLE (vectoring) mode: the input angle is always zero.
  assign co_z = '0;

  // ---------------------------------------------------------------------------
  // Round-robin pointer: moves just past the winner, holds when idle
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (issue) begin
      rr_ptr <= (grant_id == IDW_TAG'(NREQ - 1)) ? '0 : grant_id + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Issue register towards the core (one cycle after the handshake)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      co_dv <= 1'b0;
      co_x  <= '0;
      co_y  <= '0;
    end else begin
      co_dv <= issue;
      if (issue) begin
        co_x <= grant_x;
        co_y <= grant_y;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Tag FIFO
  // ---------------------------------------------------------------------------
  // NOTE: the tag storage has no reset; an entry is only ever read after it
  // has been written, and the pointers/counter alone define what is valid.
  always_ff @(posedge clk) begin
    if (issue) begin
      tag_mem[wr_ptr] <= grant_id;
    end
  end

  // Pointers are exactly PW bits wide, so they wrap modulo TDEPTH naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      outstanding <= '0;
    end else begin
      if (issue) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      // A simultaneous push and pop leaves the occupancy unchanged.
      unique case ({issue, pop})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Result register: head tag joins the core output one cycle later
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_id    <= '0;
      res_angle <= '0;
      res_amp   <= '0;
    end else begin
      res_valid <= pop;
      if (pop) begin
        res_id    <= tag_mem[rd_ptr];
        res_angle <= ci_angle;
        res_amp   <= ci_amp;
      end
    end
  end

  // A core output with no tag waiting means issue bookkeeping and the core
  // disagree (typically data left in the core across a reset); the flag
  // stays set until the next reset so software can find it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_orphan <= 1'b0;
    end else if (ci_dv && fifo_empty) begin
      err_orphan <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cordic_arb.sv
// -----------------------------------------------------------------------------
// tb_cordic_arb
//
// Drives cordic_arb with a behavioural CORDIC stub (fixed latency, ideal
// atan2/magnitude) and compares every cycle against a transaction-level model:
// a queue of in-flight requester ids, a round-robin pointer and a sticky error
// bit. Directed sequences cover single issue, contention, FIFO full,
// simultaneous push/pop, orphan outputs and reset in mid-flight; a randomized
// phase follows.
// -----------------------------------------------------------------------------
module tb_cordic_arb;

  localparam int  NREQ    = 4;
  localparam int  IDW     = 16;
  localparam int  ODW     = IDW + 2;
  localparam int  AW      = 20;
  localparam int  TDEPTH  = 32;
  localparam int  IDW_TAG = 2;
  localparam int  CW      = 6;
  localparam int  LAT     = 6;   // stub core latency, co_dv -> ci_dv
  localparam real PI      = 3.14159265358979323846;

  typedef enum logic [1:0] { M_CORE, M_OFF, M_PULSE } ci_mode_e;

  typedef struct {
    logic           dv;
    logic [AW-1:0]  ang;
    logic [ODW-1:0] amp;
  } core_item_t;

  typedef struct {
    logic [NREQ-1:0] v;
    logic [NREQ-1:0] rdy;
  } arb_vec_t;

  logic                clk;
  logic                rst_n;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*IDW-1:0] req_x;
  logic [NREQ*IDW-1:0] req_y;
  logic                co_dv;
  logic [IDW-1:0]      co_x;
  logic [IDW-1:0]      co_y;
  logic [AW-1:0]       co_z;
  logic                ci_dv;
  logic [AW-1:0]       ci_angle;
  logic [ODW-1:0]      ci_amp;
  logic                res_valid;
  logic [IDW_TAG-1:0]  res_id;
  logic [AW-1:0]       res_angle;
  logic [ODW-1:0]      res_amp;
  logic [CW-1:0]       outstanding;
  logic                err_orphan;

  cordic_arb #(
    .NREQ(NREQ), .IDW(IDW), .ODW(ODW), .AW(AW), .TDEPTH(TDEPTH), .IDW_TAG(IDW_TAG)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_x(req_x), .req_y(req_y),
    .co_dv(co_dv), .co_x(co_x), .co_y(co_y), .co_z(co_z),
    .ci_dv(ci_dv), .ci_angle(ci_angle), .ci_amp(ci_amp),
    .res_valid(res_valid), .res_id(res_id), .res_angle(res_angle), .res_amp(res_amp),
    .outstanding(outstanding), .err_orphan(err_orphan)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Stub core pipeline and reference model state
  core_item_t         pipe [LAT];
  int                 mq [$];       // requester ids in flight, oldest first
  int                 m_ptr;
  bit                 m_err;
  logic               e_co_dv;
  logic [IDW-1:0]     e_co_x, e_co_y;
  logic               e_res_valid;
  logic [IDW_TAG-1:0] e_res_id;
  logic [AW-1:0]      e_res_angle;
  logic [ODW-1:0]     e_res_amp;

  // DUT outputs as seen in the most recent cycle
  logic [NREQ-1:0]    obs_ready;
  logic               obs_co_dv;
  logic [IDW-1:0]     obs_co_x, obs_co_y;
  logic               obs_res_valid;
  logic [IDW_TAG-1:0] obs_res_id;
  logic [AW-1:0]      obs_res_angle;
  logic [CW-1:0]      obs_outst;
  logic               obs_err;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [AW-1:0] ang_of(input logic [IDW-1:0] x, input logic [IDW-1:0] y);
    int  xi, yi;
    real a;
    xi = int'($signed(x));
    yi = int'($signed(y));
    a  = $atan2(real'(yi), real'(xi));
    if (a < 0.0) a = a + 2.0 * PI;
    return AW'(int'(a / (2.0 * PI) * (2.0 ** AW)));
  endfunction

  function automatic logic [ODW-1:0] amp_of(input logic [IDW-1:0] x, input logic [IDW-1:0] y);
    int xi, yi;
    xi = int'($signed(x));
    yi = int'($signed(y));
    return ODW'(int'($sqrt(real'(xi) * real'(xi) + real'(yi) * real'(yi))));
  endfunction

  function automatic logic [NREQ*IDW-1:0] rnd_vec();
    logic [NREQ*IDW-1:0] r;
    for (int i = 0; i < NREQ; i++) r[i*IDW +: IDW] = IDW'($urandom);
    return r;
  endfunction

  task automatic shift_pipe(input core_item_t s);
    for (int i = LAT - 1; i > 0; i--) pipe[i] = pipe[i-1];
    pipe[0] = s;
  endtask

  // One clock cycle: drive inputs just after a rising edge, compare at the
  // falling edge, then advance the model across the next rising edge.
  task automatic cycle(input logic [NREQ-1:0] v, input logic [NREQ*IDW-1:0] xs,
                       input logic [NREQ*IDW-1:0] ys, input ci_mode_e mode);
    bit              found;
    int              g;
    logic [NREQ-1:0] exp_rdy;
    core_item_t      s;
    req_valid = v;
    req_x     = xs;
    req_y     = ys;
    case (mode)
      M_CORE: begin
        ci_dv = pipe[LAT-1].dv; ci_angle = pipe[LAT-1].ang; ci_amp = pipe[LAT-1].amp;
      end
      M_OFF: begin
        ci_dv = 1'b0; ci_angle = AW'($urandom); ci_amp = ODW'($urandom);
      end
      default: begin
        ci_dv = 1'b1; ci_angle = AW'($urandom); ci_amp = ODW'($urandom);
      end
    endcase
    found = 1'b0;
    g     = 0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && v[(m_ptr + k) % NREQ]) begin
        found = 1'b1;
        g     = (m_ptr + k) % NREQ;
      end
    end
    exp_rdy = (found && mq.size() < TDEPTH) ? (NREQ'(1) << g) : '0;

    @(negedge clk);
    obs_ready = req_ready;   obs_co_dv = co_dv;   obs_co_x = co_x;   obs_co_y = co_y;
    obs_res_valid = res_valid; obs_res_id = res_id; obs_res_angle = res_angle;
    obs_outst = outstanding; obs_err = err_orphan;
    check("req_ready", req_ready, exp_rdy);
    check("co_dv", co_dv, e_co_dv);
    check("co_x", co_x, e_co_x);
    check("co_y", co_y, e_co_y);
    check("co_z", co_z, 0);
    check("res_valid", res_valid, e_res_valid);
    check("res_id", res_id, e_res_id);
    check("res_angle", res_angle, e_res_angle);
    check("res_amp", res_amp, e_res_amp);
    check("outstanding", outstanding, mq.size());
    check("err_orphan", err_orphan, m_err);
    s.dv  = co_dv;
    s.ang = ang_of(co_x, co_y);
    s.amp = amp_of(co_x, co_y);

    @(posedge clk);
    if (ci_dv && mq.size() == 0) m_err = 1'b1;
    e_co_dv     = (exp_rdy != '0);
    e_res_valid = ci_dv && (mq.size() > 0);
    if (e_res_valid) begin
      e_res_id    = IDW_TAG'(mq.pop_front());
      e_res_angle = ci_angle;
      e_res_amp   = ci_amp;
    end
    if (exp_rdy != '0) begin
      e_co_x = xs[g*IDW +: IDW];
      e_co_y = ys[g*IDW +: IDW];
      mq.push_back(g);
      m_ptr = (g + 1) % NREQ;
    end
    shift_pipe(s);
    #1;
  endtask

  task automatic idle(input ci_mode_e mode);
    cycle('0, rnd_vec(), rnd_vec(), mode);
  endtask

  // Reset for ncyc rising edges. The stub core keeps shifting (it has no
  // reset of its own) unless clear_pipe asks for it to be flushed.
  task automatic do_reset(input int ncyc, input bit clear_pipe);
    core_item_t z;
    z.dv = 1'b0; z.ang = '0; z.amp = '0;
    rst_n     = 1'b0;
    req_valid = '1;
    ci_dv     = 1'b0;
    #1;
    check("rst_ready", req_ready, 0);
    check("rst_co_dv", co_dv, 0);
    check("rst_co_x", co_x, 0);
    check("rst_co_y", co_y, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_id", res_id, 0);
    check("rst_res_angle", res_angle, 0);
    check("rst_res_amp", res_amp, 0);
    check("rst_outstanding", outstanding, 0);
    check("rst_err_orphan", err_orphan, 0);
    req_valid = '0;
    mq.delete();
    m_ptr = 0; m_err = 1'b0;
    e_co_dv = 1'b0; e_co_x = '0; e_co_y = '0;
    e_res_valid = 1'b0; e_res_id = '0; e_res_angle = '0; e_res_amp = '0;
    repeat (ncyc) begin
      @(posedge clk);
      shift_pipe(z);
    end
    if (clear_pipe) for (int i = 0; i < LAT; i++) pipe[i] = z;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    shift_pipe(z);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1, "watchdog");
  end

  initial begin
    arb_vec_t            tbl [16];
    logic [NREQ*IDW-1:0] xs, ys;
    int                  cnt, lat, r;
    ci_mode_e            mode;

    // Contention table, starting from rr_ptr=0 with an empty FIFO.
    tbl[0]  = '{4'b1111, 4'b0001};  tbl[1]  = '{4'b1111, 4'b0010};
    tbl[2]  = '{4'b1111, 4'b0100};  tbl[3]  = '{4'b1111, 4'b1000};
    tbl[4]  = '{4'b1111, 4'b0001};  tbl[5]  = '{4'b1111, 4'b0010};
    tbl[6]  = '{4'b1111, 4'b0100};  tbl[7]  = '{4'b1111, 4'b1000};
    tbl[8]  = '{4'b0000, 4'b0000};  tbl[9]  = '{4'b0110, 4'b0010};
    tbl[10] = '{4'b0011, 4'b0001};  tbl[11] = '{4'b1000, 4'b1000};
    tbl[12] = '{4'b1001, 4'b0001};  tbl[13] = '{4'b0001, 4'b0001};
    tbl[14] = '{4'b1100, 4'b0100};  tbl[15] = '{4'b0100, 4'b0100};

    req_valid = '0; req_x = '0; req_y = '0;
    ci_dv = 1'b0; ci_angle = '0; ci_amp = '0;
    do_reset(2, 1'b1);

    // Single request from requester 2 with x=y=100: angle is pi/4.
    xs = rnd_vec(); ys = rnd_vec();
    xs[2*IDW +: IDW] = IDW'(100);
    ys[2*IDW +: IDW] = IDW'(100);
    cycle(4'b0100, xs, ys, M_CORE);
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      idle(M_CORE);
      if (k == 1) begin
        check("single_co_dv", obs_co_dv, 1);
        check("single_co_x", obs_co_x, 100);
        check("single_co_y", obs_co_y, 100);
      end
      if (obs_res_valid && lat < 0) begin
        lat = k;
        check("single_res_id", obs_res_id, 2);
        check("single_res_angle", obs_res_angle, 20'h20000);
      end
    end
    check("single_latency", lat, LAT + 2);

    // Contention and assorted valid patterns from the table; then drain.
    do_reset(2, 1'b1);
    foreach (tbl[i]) begin
      cycle(tbl[i].v, rnd_vec(), rnd_vec(), M_CORE);
      check("tbl_ready", obs_ready, tbl[i].rdy);
    end
    repeat (LAT + 4) idle(M_CORE);
    check("tbl_drained", obs_outst, 0);

    // Full: core silent, requester 0 always valid.
    do_reset(2, 1'b1);
    cnt = 0;
    for (int i = 0; i < TDEPTH + 4; i++) begin
      cycle(4'b0001, rnd_vec(), rnd_vec(), M_OFF);
      if (obs_ready[0]) cnt++;
    end
    check("full_issue_count", cnt, TDEPTH);
    check("full_outstanding", obs_outst, TDEPTH);
    check("full_ready", obs_ready, 0);
    cycle(4'b0001, rnd_vec(), rnd_vec(), M_PULSE);
    check("full_pulse_ready", obs_ready, 0);
    cycle(4'b0001, rnd_vec(), rnd_vec(), M_OFF);
    check("full_after_pulse_ready", obs_ready, 4'b0001);
    check("full_after_pulse_outst", obs_outst, TDEPTH - 1);
    cycle(4'b0001, rnd_vec(), rnd_vec(), M_OFF);
    check("full_again_ready", obs_ready, 0);
    check("full_again_outst", obs_outst, TDEPTH);

    // Simultaneous push and pop at outstanding=5 (ids 0,1,2,3,0 in flight).
    do_reset(2, 1'b1);
    repeat (5) cycle(4'b1111, rnd_vec(), rnd_vec(), M_OFF);
    cycle(4'b1111, rnd_vec(), rnd_vec(), M_PULSE);
    check("pushpop_ready", obs_ready, 4'b0010);
    check("pushpop_outst_before", obs_outst, 5);
    idle(M_OFF);
    check("pushpop_outst_after", obs_outst, 5);
    check("pushpop_res_valid", obs_res_valid, 1);
    check("pushpop_res_id", obs_res_id, 0);

    // Orphan: core output with nothing in flight; flag is sticky.
    do_reset(2, 1'b1);
    idle(M_PULSE);
    idle(M_OFF);
    check("orphan_set", obs_err, 1);
    check("orphan_no_result", obs_res_valid, 0);
    repeat (5) idle(M_OFF);
    check("orphan_sticky", obs_err, 1);

    // Mid-flight reset: three issues, reset, the core still returns data.
    do_reset(2, 1'b1);
    repeat (3) cycle(4'b1111, rnd_vec(), rnd_vec(), M_CORE);
    do_reset(2, 1'b0);
    repeat (LAT + 3) idle(M_CORE);
    check("midreset_orphan", obs_err, 1);
    check("midreset_outst", obs_outst, 0);

    // Randomized traffic against the model.
    do_reset(2, 1'b1);
    for (int i = 0; i < 600; i++) begin
      r = int'($urandom_range(0, 99));
      mode = (r < 70) ? M_CORE : ((r < 88) ? M_OFF : M_PULSE);
      cycle(NREQ'($urandom), rnd_vec(), rnd_vec(), mode);
    end
    repeat (LAT + 4) idle(M_CORE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cordic_arb.md
CORDIC_ARB -- requirements
Module: cordic_arb

Interface
REQ-001 SHALL have parameter NREQ, default 4: number of requesters; supported range 2..8.
REQ-002 SHALL have parameter IDW, default 16: requester x/y width and cordic_core input width.
REQ-003 SHALL have parameter ODW, default IDW+2: cordic_core amplitude width.
REQ-004 SHALL have parameter AW, default 20: cordic_core angle width; 2^AW corresponds to 2*pi.
REQ-005 SHALL have parameter TDEPTH, default 32: tag FIFO depth; power of two; must be at least the cordic_core latency.
REQ-006 SHALL have parameter IDW_TAG, default clog2(NREQ): requester-id width.
REQ-007 SHALL have ports in this order:
- clk  in  1  sole clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept.
- req_x  in  NREQ*IDW  packed x operands; requester i occupies bits [i*IDW +: IDW].
- req_y  in  NREQ*IDW  packed y operands, same packing as req_x.
- co_dv  out  1  to cordic_core pi_dv.
- co_x  out  IDW  to cordic_core pi_x.
- co_y  out  IDW  to cordic_core pi_y.
- co_z  out  AW  to cordic_core pi_z; tied to 0 (ANGLE mode).
- ci_dv  in  1  from cordic_core po_dv.
- ci_angle  in  AW  from cordic_core po_angle.
- ci_amp  in  ODW  from cordic_core po_amp.
- res_valid  out  1  one-cycle result strobe.
- res_id  out  IDW_TAG  requester that owns the result.
- res_angle  out  AW  result angle.
- res_amp  out  ODW  result amplitude.
- outstanding  out  clog2(TDEPTH)+1  number of tags in flight.
- err_orphan  out  1  sticky error flag.

Function
REQ-008 SHALL perform round-robin arbitration: the grant is the first requester with req_valid=1, searching from pointer rr_ptr upward and wrapping past NREQ-1 back to 0.
REQ-009 SHALL drive req_ready[i]=1 only when i is the current grant and the tag FIFO is not full; req_ready SHALL be combinational from req_valid, rr_ptr and the full flag.
REQ-010 SHALL treat a handshake (req_valid[i] and req_ready[i] both 1) as an issue, and SHALL allow at most one issue per cycle.
REQ-011 SHALL, on an issue, register co_dv=1 and the granted req_x/req_y onto co_x/co_y at the next edge (1-cycle issue latency); otherwise co_dv=0 and co_x/co_y hold their previous values.
REQ-012 SHALL, on an issue, push the granted id into the tag FIFO in the same cycle and set rr_ptr=(grant+1) mod NREQ; with no issue, rr_ptr SHALL hold.
REQ-013 SHALL, when ci_dv=1 and the FIFO is non-empty, pop the head tag and register it as res_valid=1, res_id=tag, res_angle=ci_angle, res_amp=ci_amp (1-cycle result latency).
REQ-014 SHALL, when ci_dv=1 and the FIFO is empty, set err_orphan=1 (sticky until reset) and keep res_valid=0.
REQ-015 SHALL hold res_angle/res_amp/res_id when res_valid=0 and SHALL provide no result back-pressure; a consumer must accept every res_valid strobe.
REQ-016 SHALL handle a push and a pop in the same cycle as follows: outstanding unchanged, and both take effect. Full is evaluated before the pop, so no issue is accepted in a cycle where the FIFO was full at the start.
REQ-017 SHALL wrap the FIFO read/write pointers modulo TDEPTH; outstanding SHALL equal pushes minus pops and never exceed TDEPTH.
REQ-018 SHALL return results in issue order, because the tag FIFO is strictly FIFO and cordic_core is an in-order pipeline.

Reset
REQ-019 SHALL, while rst_n=0, immediately force the following values: req_ready=0, co_dv=0, co_x=0, co_y=0, res_valid=0, res_id=0, res_angle=0, res_amp=0, outstanding=0, err_orphan=0, rr_ptr=0, FIFO pointers=0.
REQ-020 SHALL treat reset asserted mid-operation as discarding all in-flight tags; a ci_dv arriving after deassertion with an empty FIFO raises err_orphan per REQ-014.
REQ-021 SHALL begin arbitrating on the first rising edge after rst_n deasserts.

Verification
REQ-022 Single request: requester 2 presents x=100, y=100 -> co_dv=1 with co_x=100, co_y=100 one cycle later; res_valid with res_id=2 and res_angle of about 2^AW/8 (0x20000) after core latency +1.
REQ-023 Contention: all four requesters held valid for 8 cycles -> grants follow the sequence 0,1,2,3,0,1,2,3 and results carry res_id in the same order.
REQ-024 Full: hold ci_dv=0 (core stubbed), keep requester 0 valid -> exactly TDEPTH issues are accepted, then outstanding=32 and req_ready=0; a single ci_dv pulse allows one more issue on the following cycle.
REQ-025 Simultaneous push and pop at outstanding=5 -> outstanding stays 5 and res_id matches the oldest tag.
REQ-026 Orphan: ci_dv pulse with outstanding=0 -> err_orphan=1 and res_valid=0; err_orphan remains 1 until rst_n=0.
REQ-027 Mid-flight reset: 3 issues, assert rst_n=0 for 2 cycles -> all outputs return to zero; the late ci_dv pulses set err_orphan.
